// File: rtl/toeplitz_colstream.sv
// Streams the columns of a Toeplitz matrix built from a row seed and a column seed,
// STRIDE bits per step, with valid/ready handshaking and one-shot or continuous mode.
module toeplitz_colstream #(
    parameter  int N      = 256,
    parameter  int L      = 128,
    parameter  int STRIDE = 1,
    localparam int NCOL   = N / STRIDE,
    localparam int IW     = (NCOL > 1) ? $clog2(NCOL) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          seed_valid,
    output logic          seed_ready,
    input  logic [N-1:0]  seed_row,
    input  logic [L-1:0]  seed_col,
    input  logic          seed_cont,
    input  logic          flush,
    output logic          col_valid,
    input  logic          col_ready,
    output logic [L-1:0]  col,
    output logic [IW-1:0] col_idx,
    output logic          col_last
);

    generate
        if (!(STRIDE >= 1 && STRIDE < L && (N % STRIDE) == 0 && (N / STRIDE) >= 2)) begin : g_bad_params
            $error("toeplitz_colstream: illegal N/L/STRIDE combination");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NCOL - 1);
    localparam logic [IW-1:0] PENULT   = IW'(NCOL - 2);

    state_t         state;
    logic [N-1:0]   row_w;
    logic [N-1:0]   row_s;
    logic [L-1:0]   col_s;
    logic           cont_s;
    logic           at_last;

    assign at_last = (col_idx == LAST_IDX);

    // NOTE: all state here is sequential and uses non-blocking assignments so every
    // register samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            seed_ready <= 1'b1;
            col_valid  <= 1'b0;
            col_last   <= 1'b0;
            col        <= '0;
            col_idx    <= '0;
            row_w      <= '0;
            row_s      <= '0;
            col_s      <= '0;
            cont_s     <= 1'b0;
        end else if (flush) begin
            // Abort wins over any transfer or seed offer in the same cycle.
            state      <= IDLE;
            seed_ready <= 1'b1;
            col_valid  <= 1'b0;
            col_last   <= 1'b0;
            col_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_valid) begin
                        row_s      <= seed_row;
                        col_s      <= seed_col;
                        cont_s     <= seed_cont;
                        row_w      <= seed_row;
                        col        <= seed_col;
                        col_idx    <= '0;
                        state      <= RUN;
                        seed_ready <= 1'b0;
                        col_valid  <= 1'b1;
                        col_last   <= 1'b0;
                    end
                end
                RUN: begin
                    if (col_ready) begin
                        if (!at_last) begin
                            col      <= {row_w[N-1 -: STRIDE], col[L-1:STRIDE]};
                            row_w    <= row_w << STRIDE;
                            col_idx  <= col_idx + 1'b1;
                            col_last <= (col_idx == PENULT);
                        end else if (cont_s) begin
                            // Wrap straight back to column 0 with no bubble.
                            col      <= col_s;
                            row_w    <= row_s;
                            col_idx  <= '0;
                            col_last <= 1'b0;
                        end else begin
                            state      <= IDLE;
                            seed_ready <= 1'b1;
                            col_valid  <= 1'b0;
                            col_last   <= 1'b0;
                            col_idx    <= '0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    seed_ready <= 1'b1;
                    col_valid  <= 1'b0;
                    col_last   <= 1'b0;
                    col_idx    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toeplitz_colstream.sv
// Directed bench for toeplitz_colstream: N=8, L=4 with STRIDE 1 and 2, one-shot,
// continuous, backpressure, flush and asynchronous reset scenarios.
module tb_toeplitz_colstream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // STRIDE = 1 instance
    logic       a_seed_valid, a_seed_ready, a_seed_cont, a_flush;
    logic       a_col_valid, a_col_ready, a_col_last;
    logic [7:0] a_seed_row;
    logic [3:0] a_seed_col, a_col;
    logic [2:0] a_col_idx;

    // STRIDE = 2 instance
    logic       b_seed_valid, b_seed_ready, b_seed_cont, b_flush;
    logic       b_col_valid, b_col_ready, b_col_last;
    logic [7:0] b_seed_row;
    logic [3:0] b_seed_col, b_col;
    logic [1:0] b_col_idx;

    toeplitz_colstream #(.N(8), .L(4), .STRIDE(1)) u_s1 (
        .clk(clk), .reset(reset),
        .seed_valid(a_seed_valid), .seed_ready(a_seed_ready),
        .seed_row(a_seed_row), .seed_col(a_seed_col), .seed_cont(a_seed_cont),
        .flush(a_flush),
        .col_valid(a_col_valid), .col_ready(a_col_ready),
        .col(a_col), .col_idx(a_col_idx), .col_last(a_col_last)
    );

    toeplitz_colstream #(.N(8), .L(4), .STRIDE(2)) u_s2 (
        .clk(clk), .reset(reset),
        .seed_valid(b_seed_valid), .seed_ready(b_seed_ready),
        .seed_row(b_seed_row), .seed_col(b_seed_col), .seed_cont(b_seed_cont),
        .flush(b_flush),
        .col_valid(b_col_valid), .col_ready(b_col_ready),
        .col(b_col), .col_idx(b_col_idx), .col_last(b_col_last)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_a [8] = '{4'h3, 4'h9, 4'h4, 4'hA, 4'h5, 4'h2, 4'h9, 4'h4};
    logic [3:0] exp_b [4] = '{4'h3, 4'h8, 4'hA, 4'h6};
    logic [3:0] exp_f [8] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF};

    task automatic seed_a(input logic [7:0] row, input logic [3:0] c, input logic cont);
        a_seed_row   = row;
        a_seed_col   = c;
        a_seed_cont  = cont;
        a_seed_valid = 1'b1;
        tick();
        a_seed_valid = 1'b0;
    endtask

    initial begin
        a_seed_valid = 0; a_seed_cont = 0; a_flush = 0; a_col_ready = 0;
        a_seed_row = '0; a_seed_col = '0;
        b_seed_valid = 0; b_seed_cont = 0; b_flush = 0; b_col_ready = 0;
        b_seed_row = '0; b_seed_col = '0;

        // Reset state
        reset = 1'b1;
        #12;
        check("rst_seed_ready", a_seed_ready, 1);
        check("rst_col_valid", a_col_valid, 0);
        check("rst_col", a_col, 0);
        check("rst_col_idx", a_col_idx, 0);
        reset = 1'b0;
        tick();
        check("post_rst_seed_ready", a_seed_ready, 1);
        check("post_rst_col_last", a_col_last, 0);

        // One-shot, STRIDE 1, always ready
        a_col_ready = 1'b1;
        seed_a(8'hA5, 4'h3, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("os_valid", a_col_valid, 1);
            check("os_ready_low", a_seed_ready, 0);
            check("os_col", a_col, exp_a[k]);
            check("os_idx", a_col_idx, k);
            check("os_last", a_col_last, (k == 7));
            tick();
        end
        check("os_end_valid", a_col_valid, 0);
        check("os_end_seed_ready", a_seed_ready, 1);
        check("os_end_idx", a_col_idx, 0);

        // One-shot, STRIDE 2
        b_col_ready  = 1'b1;
        b_seed_row   = 8'hA5;
        b_seed_col   = 4'h3;
        b_seed_cont  = 1'b0;
        b_seed_valid = 1'b1;
        tick();
        b_seed_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("s2_valid", b_col_valid, 1);
            check("s2_col", b_col, exp_b[k]);
            check("s2_idx", b_col_idx, k);
            check("s2_last", b_col_last, (k == 3));
            tick();
        end
        check("s2_end_valid", b_col_valid, 0);
        check("s2_end_seed_ready", b_seed_ready, 1);

        // Backpressure: same sequence, outputs checked on every cycle incl. stalls
        begin
            int k = 0;
            int budget = 200;
            a_col_ready = 1'b0;
            seed_a(8'hA5, 4'h3, 1'b0);
            while (k < 8 && budget > 0) begin
                check("bp_valid", a_col_valid, 1);
                check("bp_col", a_col, exp_a[k]);
                check("bp_idx", a_col_idx, k);
                check("bp_last", a_col_last, (k == 7));
                a_col_ready = 1'($urandom_range(0, 1));
                if (a_col_ready) k++;
                tick();
                budget--;
            end
            check("bp_budget", (budget > 0), 1);
            check("bp_end_valid", a_col_valid, 0);
        end

        // Continuous mode: three matrices, no bubble; seed offers in RUN are ignored
        a_col_ready = 1'b1;
        seed_a(8'hA5, 4'h3, 1'b1);
        for (int i = 0; i < 24; i++) begin
            check("ct_valid", a_col_valid, 1);
            check("ct_col", a_col, exp_a[i % 8]);
            check("ct_idx", a_col_idx, i % 8);
            check("ct_last", a_col_last, ((i % 8) == 7));
            if (i == 10) begin
                check("ct_seed_ready", a_seed_ready, 0);
                a_seed_row = 8'hFF; a_seed_col = 4'h0; a_seed_cont = 1'b0; a_seed_valid = 1'b1;
            end else begin
                a_seed_valid = 1'b0;
            end
            tick();
        end
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("ct_flush_valid", a_col_valid, 0);

        // Flush at idx 3 with a simultaneous transfer
        seed_a(8'hA5, 4'h3, 1'b0);
        tick(); tick(); tick();
        check("fl_idx3", a_col_idx, 3);
        check("fl_col3", a_col, 4'hA);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("fl_valid", a_col_valid, 0);
        check("fl_seed_ready", a_seed_ready, 1);
        check("fl_idx", a_col_idx, 0);
        seed_a(8'hFF, 4'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("fl_valid_run", a_col_valid, 1);
            check("fl_col", a_col, exp_f[k]);
            check("fl_run_idx", a_col_idx, k);
            tick();
        end
        check("fl_end_valid", a_col_valid, 0);

        // Asynchronous reset mid-matrix at idx 5
        seed_a(8'hA5, 4'h3, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        check("ar_idx5", a_col_idx, 5);
        check("ar_valid_before", a_col_valid, 1);
        a_col_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid_async", a_col_valid, 0);
        check("ar_seed_ready_async", a_seed_ready, 1);
        tick();
        reset = 1'b0;
        #1;
        check("ar_seed_ready", a_seed_ready, 1);
        check("ar_idx", a_col_idx, 0);
        check("ar_col", a_col, 0);
        a_col_ready = 1'b1;
        tick(); tick();
        check("ar_no_stream", a_col_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toeplitz_colstream.md
TOEPLITZ_COLSTREAM -- requirements
Module: toeplitz_colstream

Interface
REQ-001 The block SHALL expose parameter N, default 256, the Toeplitz row-seed length in bits.
REQ-002 The block SHALL expose parameter L, default 128, the column length in bits.
REQ-003 The block SHALL expose parameter STRIDE, default 1, the bits shifted per column step; legal when 1 <= STRIDE < L, N % STRIDE == 0 and N/STRIDE >= 2; otherwise elaboration SHALL fail.
REQ-004 Derived constants SHALL be NCOL = N/STRIDE (columns per matrix) and IW = max(1, clog2(NCOL)).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 seed_valid  input  1  seed offer.
REQ-008 seed_ready  output  1  block accepts a seed this cycle.
REQ-009 seed_row  input  N  first-row seed; bit N-1 is consumed first.
REQ-010 seed_col  input  L  first-column seed; it is column 0.
REQ-011 seed_cont  input  1  sampled with the seed: 1 = continuous (wrap), 0 = one-shot.
REQ-012 flush  input  1  synchronous abort to IDLE.
REQ-013 col_valid  output  1  col, col_idx and col_last are valid.
REQ-014 col_ready  input  1  downstream accepts the column.
REQ-015 col  output  L  current Toeplitz column.
REQ-016 col_idx  output  IW  index k of the current column, 0..NCOL-1.
REQ-017 col_last  output  1  high with col_valid when col_idx == NCOL-1.

Function
REQ-018 The FSM SHALL have two states, IDLE and RUN; seed_ready SHALL be 1 only in IDLE, and col_valid SHALL be 1 only in RUN.
REQ-019 In IDLE, seed_valid=1 SHALL capture seed_row, seed_col and seed_cont into stored registers, load the working column with seed_col, load the working row with seed_row, set col_idx to 0 and enter RUN; col_valid SHALL assert the next cycle (one-cycle latency).
REQ-020 A beat SHALL transfer when col_valid && col_ready; while col_valid && !col_ready, col, col_idx and col_last SHALL hold stable.
REQ-021 On a transfer with col_idx < NCOL-1: next col = {row_w[N-1 -: STRIDE], col[L-1:STRIDE]}, row_w <= row_w << STRIDE, col_idx <= col_idx + 1.
REQ-022 Consequently, column k SHALL equal the L-bit window of the Toeplitz matrix whose top STRIDE bits are seed_row[N-1-(k-1)*STRIDE -: STRIDE] for k >= 1.
REQ-023 On a transfer with col_idx == NCOL-1 and stored mode continuous: reload col from the stored seed_col, reload row_w from the stored seed_row, set col_idx to 0 and stay in RUN, with no bubble cycle.
REQ-024 On a transfer with col_idx == NCOL-1 and stored mode one-shot: return to IDLE; col_valid SHALL be 0 the next cycle.
REQ-025 A new seed SHALL be accepted only in IDLE; seed_valid in RUN SHALL be ignored and leave the stored seed unchanged.
REQ-026 flush=1 SHALL force IDLE on the next edge, with col_idx 0 and col_valid 0, and SHALL take priority over a simultaneous transfer or seed acceptance.
REQ-027 In IDLE, col SHALL hold its last value and col_idx SHALL be 0; downstream SHALL ignore both.
REQ-028 No arithmetic SHALL overflow: col_idx SHALL never exceed NCOL-1, including for non-power-of-two NCOL.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE, regardless of clk.
REQ-030 Reset SHALL clear col, the working row, the stored seeds, col_idx and stored mode to 0, and SHALL clear col_valid and col_last.
REQ-031 seed_ready SHALL be 1 while reset is held and after release.
REQ-032 Reset asserted mid-matrix SHALL discard the current stream; the first post-reset column SHALL come only from a new seed.

Verification
REQ-033 N=8, L=4, STRIDE=1, seed_row=8'hA5, seed_col=4'h3, one-shot, col_ready=1: col SHALL be 3,9,4,A,5,2,9,4 with col_idx 0..7 and col_last on idx 7 only, then IDLE and seed_ready=1.
REQ-034 N=8, L=4, STRIDE=2, same seeds, one-shot: col SHALL be 3,8,A,6 with col_last on the fourth beat.
REQ-035 Continuous mode, STRIDE=1, same seeds: after 4'h4 (idx 7), the next cycle SHALL show 4'h3 at idx 0, with no idle cycle, for at least 3 matrices.
REQ-036 Backpressure: col_ready random 50%: the sequence SHALL be identical to REQ-033, and outputs SHALL be stable across every stalled cycle.
REQ-037 flush asserted at idx 3 together with col_ready=1: next cycle col_valid=0 and seed_ready=1; a new seed 8'hFF/4'h0 SHALL then yield 0,8,C,E,F,F,F,F.
REQ-038 reset pulsed asynchronously mid-beat at idx 5: col_valid SHALL drop immediately; after release, seed_ready=1, col_idx=0 and col=0.
